// File: rtl/conv_window_reader.sv
// conv_window_reader: reads one coupler row per full event and emits KERNEL x ROWS sliding windows.
// Defining CONV_WINDOW_ZERO_PAD_EN adds one all-zero column before and after every row.
module conv_window_reader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ROWS          = 3,
  parameter int unsigned KERNEL        = 3,
  parameter int unsigned MAX_ROW_WIDTH = 1024,
  parameter int unsigned ADDR_WIDTH    = $clog2(MAX_ROW_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [31:0]                         row_width,
  input  logic                                full,
  input  logic [ROWS*DATA_WIDTH-1:0]          col_in,
  output logic                                r_en,
  output logic [ADDR_WIDTH-1:0]               r_add,
  output logic [KERNEL*ROWS*DATA_WIDTH-1:0]   win_data,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic                                win_last,
  output logic                                busy,
  output logic                                cfg_err
);

  localparam int unsigned COL_W  = ROWS * DATA_WIDTH;
  localparam int unsigned WIN_W  = KERNEL * COL_W;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned FILL_W = $clog2(KERNEL + 1);
`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]    w_q;
  logic [CNT_W-1:0]    col_cnt;
  logic [FILL_W-1:0]   fill;
  logic                tail_done;
  logic [COL_W-1:0]    skid;
  logic                skid_vld;
  logic                rd_ret;

  logic                start;
  logic                bad_cfg;
  logic                stall;
  logic                all_in;
  logic                pad_tail;
  logic                do_shift;
  logic                shift_last;
  logic                full_win;
  logic [COL_W-1:0]    new_col;

  assign r_add = addr_q;
  assign busy  = (state != S_IDLE);

  // Next-state and datapath control; r_en reacts to the current-cycle stall so no return is ever lost.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    bad_cfg    = 1'b0;
    r_en       = 1'b0;
    stall      = win_valid & ~win_ready;
    all_in     = (col_cnt == w_q) & (tail_done | ~PAD);
    pad_tail   = PAD & (state == S_DRAIN) & (col_cnt == w_q) & ~tail_done;
    do_shift   = (skid_vld | rd_ret | pad_tail) & ~stall;
    full_win   = (fill >= FILL_W'(KERNEL - 1));
    shift_last = PAD ? pad_tail : (col_cnt == (w_q - CNT_W'(1)));
    new_col    = '0;
    if (skid_vld)    new_col = skid;
    else if (rd_ret) new_col = col_in;

    case (state)
      S_IDLE: begin
        if (full) begin
          if (row_width == 32'd0 || row_width > 32'(MAX_ROW_WIDTH)) begin
            bad_cfg = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        r_en = ~skid_vld & ~stall;
        if (r_en && ({1'b0, addr_q} == (w_q - CNT_W'(1)))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (all_in && (~win_valid || win_ready)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Read address, column capture/skid, window shift register and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      w_q       <= '0;
      col_cnt   <= '0;
      fill      <= '0;
      tail_done <= 1'b0;
      skid      <= '0;
      skid_vld  <= 1'b0;
      rd_ret    <= 1'b0;
      win_data  <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      rd_ret <= r_en;
      if (bad_cfg) cfg_err <= 1'b1;
      if (start) begin
        // Clearing the register keeps windows from mixing rows; it doubles as the leading pad column.
        w_q       <= row_width[CNT_W-1:0];
        addr_q    <= '0;
        col_cnt   <= '0;
        fill      <= PAD ? FILL_W'(1) : '0;
        tail_done <= 1'b0;
        skid_vld  <= 1'b0;
        win_data  <= '0;
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end else begin
        if (r_en) addr_q <= (state_nxt == S_DRAIN) ? '0 : addr_q + ADDR_WIDTH'(1);
        if (rd_ret && stall) begin
          skid     <= col_in;
          skid_vld <= 1'b1;
        end
        if (do_shift) begin
          win_data <= {new_col, win_data[WIN_W-1:COL_W]};
          if (skid_vld) skid_vld <= 1'b0;
          if (pad_tail) tail_done <= 1'b1;
          else          col_cnt   <= col_cnt + CNT_W'(1);
          if (fill != FILL_W'(KERNEL)) fill <= fill + FILL_W'(1);
          win_valid <= full_win;
          win_last  <= full_win & shift_last;
        end else if (win_valid && win_ready) begin
          win_valid <= 1'b0;
          win_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// tb_conv_window_reader: directed rows against a window-list model built from the row width.
module tb_conv_window_reader;

  localparam int DW     = 32;
  localparam int ROWS   = 3;
  localparam int KERNEL = 3;
  localparam int MAXW   = 1024;
  localparam int AW     = 10;
  localparam int COL_W  = ROWS * DW;
  localparam int WIN_W  = KERNEL * COL_W;
`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      row_width;
  logic             full;
  logic [COL_W-1:0] col_in;
  logic             r_en;
  logic [AW-1:0]    r_add;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic             win_ready;
  logic             win_last;
  logic             busy;
  logic             cfg_err;

  conv_window_reader dut (
    .clk(clk), .rst_n(rst_n), .row_width(row_width), .full(full), .col_in(col_in),
    .r_en(r_en), .r_add(r_add), .win_data(win_data), .win_valid(win_valid),
    .win_ready(win_ready), .win_last(win_last), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int tag = 0;
  int exp_addr = 0;
  int reads = 0;
  int row_wins = 0;
  int row_lasts = 0;
  int first_ren = -1;
  int first_val = -1;
  logic [WIN_W-1:0] first_win;
  logic [WIN_W-1:0] exp_q[$];
  bit               expl_q[$];

  logic             prev_ren = 1'b0;
  logic [AW-1:0]    prev_add = '0;
  logic             prev_stall = 1'b0;
  logic [WIN_W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [COL_W-1:0] mk_col(input int t, input int a);
    logic [COL_W-1:0] c;
    c = '0;
    for (int r = 0; r < ROWS; r++) c[r*DW +: DW] = {8'(t), 8'(r), 16'(a)};
    return c;
  endfunction

  // Coupler model: one-cycle read latency, junk on the bus when nothing was read.
  logic          rd_q = 1'b0;
  logic [AW-1:0] add_q = '0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_q  <= r_en;
    add_q <= r_add;
  end
  assign col_in = rd_q ? mk_col(tag, int'(add_q)) : {COL_W{1'b1}};

  // Expected windows: slide KERNEL wide over the (optionally zero-padded) column list.
  task automatic build_expect(input int w);
    logic [COL_W-1:0] cols[$];
    logic [WIN_W-1:0] wv;
    int n;
    exp_q.delete();
    expl_q.delete();
    if (w < 1 || w > MAXW) return;
    if (PAD) cols.push_back('0);
    for (int a = 0; a < w; a++) cols.push_back(mk_col(tag, a));
    if (PAD) cols.push_back('0);
    n = cols.size();
    for (int k = 0; k + KERNEL <= n; k++) begin
      for (int c = 0; c < KERNEL; c++) wv[c*COL_W +: COL_W] = cols[k+c];
      exp_q.push_back(wv);
      expl_q.push_back(k + KERNEL == n);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ren   = 1'b0;
      prev_add   = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data_hold", win_data, prev_data);
        check("stall_valid_hold", WIN_W'(win_valid), WIN_W'(1));
      end
      if (!prev_ren) check("r_add_hold", WIN_W'(r_add), WIN_W'(prev_add));
      if (win_valid && !win_ready) check("r_en_in_stall", WIN_W'(r_en), WIN_W'(0));
      if (r_en) begin
        check("r_add_seq", WIN_W'(r_add), WIN_W'(exp_addr));
        exp_addr++;
        reads++;
        if (first_ren < 0) first_ren = cyc;
      end
      if (win_valid && first_val < 0) first_val = cyc;
      if (win_valid && win_ready) begin
        checki("window_expected", exp_q.size() > 0 ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          check("win_data", win_data, exp_q.pop_front());
          check("win_last", WIN_W'(win_last), WIN_W'(expl_q.pop_front()));
        end
        if (row_wins == 0) first_win = win_data;
        row_wins++;
        if (win_last) row_lasts++;
      end
      prev_ren   = r_en;
      prev_add   = r_add;
      prev_stall = win_valid && !win_ready;
      prev_data  = win_data;
    end
  end

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      1:       return (k % 2) == 0;
      2:       return (k % 4) == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic start_row(input int w, input int mode);
    tag++;
    exp_addr  = 0;
    reads     = 0;
    row_wins  = 0;
    row_lasts = 0;
    first_ren = -1;
    first_val = -1;
    build_expect(w);
    @(posedge clk); #1;
    row_width = 32'(w);
    full      = 1'b1;
    win_ready = rdy(mode, 0);
    @(posedge clk); #1;
    full = 1'b0;
  endtask

  task automatic run_row(input int w, input int mode, input int budget);
    bit done;
    int nwin;
    bit legal;
    legal = (w >= 1 && w <= MAXW);
    nwin  = !legal ? 0 : (PAD ? w : ((w >= KERNEL) ? w - KERNEL + 1 : 0));
    start_row(w, mode);
    done = 1'b0;
    for (int k = 1; k < budget && !done; k++) begin
      win_ready = rdy(mode, k);
      @(negedge clk);
      if (!busy) done = 1'b1;
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    checki("row_done_in_budget", int'(done), 1);
    checki("reads_per_row", reads, legal ? w : 0);
    checki("windows_per_row", row_wins, nwin);
    checki("model_queue_drained", exp_q.size(), 0);
    checki("win_last_count", row_lasts, (nwin > 0) ? 1 : 0);
    check("busy_after_row", WIN_W'(busy), WIN_W'(0));
    check("r_add_after_row", WIN_W'(r_add), WIN_W'(0));
  endtask

  initial begin
    bit found;
    rst_n     = 1'b0;
    full      = 1'b0;
    win_ready = 1'b0;
    row_width = '0;
    #1;
    check("rst_r_en", WIN_W'(r_en), WIN_W'(0));
    check("rst_r_add", WIN_W'(r_add), WIN_W'(0));
    check("rst_win_valid", WIN_W'(win_valid), WIN_W'(0));
    check("rst_win_last", WIN_W'(win_last), WIN_W'(0));
    check("rst_win_data", win_data, '0);
    check("rst_busy", WIN_W'(busy), WIN_W'(0));
    check("rst_cfg_err", WIN_W'(cfg_err), WIN_W'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back row: windows, latency and first-window contents pinned by hand.
    run_row(8, 0, 40);
    checki("w8_windows_literal", row_wins, PAD ? 8 : 6);
    checki("w8_latency", first_val - first_ren, PAD ? 3 : 4);
    check("w8_first_c2r1", WIN_W'(first_win[(2*ROWS+1)*DW +: DW]), WIN_W'(PAD ? 32'h0101_0001 : 32'h0101_0002));
    check("w8_first_c0r0", WIN_W'(first_win[0 +: DW]), WIN_W'(PAD ? 32'h0 : 32'h0100_0000));

    run_row(8, 1, 80);
    checki("w8_toggle_windows", row_wins, PAD ? 8 : 6);
    run_row(5, 2, 120);
    run_row(4, 0, 30);
    checki("w4_windows_literal", row_wins, PAD ? 4 : 2);
    run_row(2, 0, 20);
    checki("w2_windows_literal", row_wins, PAD ? 2 : 0);
    check("w2_cfg_err", WIN_W'(cfg_err), WIN_W'(0));

    run_row(0, 0, 10);
    check("w0_cfg_err", WIN_W'(cfg_err), WIN_W'(1));
    run_row(2000, 0, 10);
    check("w2000_cfg_err", WIN_W'(cfg_err), WIN_W'(1));

    run_row(1024, 0, 1100);
    checki("w1024_windows_literal", row_wins, PAD ? 1024 : 1022);

    // Reset in the middle of a row.
    start_row(8, 0);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (r_en && r_add == AW'(5)) found = 1'b1;
    end
    checki("rst_mid_found_addr5", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_r_en", WIN_W'(r_en), WIN_W'(0));
    check("mid_rst_r_add", WIN_W'(r_add), WIN_W'(0));
    check("mid_rst_win_valid", WIN_W'(win_valid), WIN_W'(0));
    check("mid_rst_win_data", win_data, '0);
    check("mid_rst_busy", WIN_W'(busy), WIN_W'(0));
    check("mid_rst_cfg_err", WIN_W'(cfg_err), WIN_W'(0));
    exp_q.delete();
    expl_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_row(8, 0, 40);
    checki("after_rst_windows", row_wins, PAD ? 8 : 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
